// File: rtl/alu8_seq_pkg.sv
// Shared definitions for the 8-bit-over-4-bit ALU sequencer.
//   WORD_W           : operand/result width (8)
//   NIB_W            : slice width (4)
//   alu8_seq_state_t : controller states IDLE -> LO -> HI -> DONE
package alu8_seq_pkg;

    localparam int WORD_W = 8;
    localparam int NIB_W  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        DONE = 2'd3
    } alu8_seq_state_t;

endpackage

// File: rtl/alu8_seq_flags.sv
// Combinational result flags for the ALU sequencer.
// Only instantiated when ALU8_SEQ_FLAGS_EN is defined.
//   word : in,  WORD_W - final assembled result
//   zero : out, 1      - word == 0
//   sign : out, 1      - most significant bit of word
module alu8_seq_flags
    import alu8_seq_pkg::*;
(
    input  logic [WORD_W-1:0] word,
    output logic              zero,
    output logic              sign
);

    assign zero = (word == '0);
    assign sign = word[WORD_W-1];

endmodule

// File: rtl/alu8_nibble_sequencer.sv
// Two-cycle controller running 8-bit ALU operations through one external
// 4-bit 74181-style slice: low nibble first, then high nibble, with the
// low-nibble carry-out chained unmodified into the high-nibble carry-in.
//
// Optional feature macro: ALU8_SEQ_FLAGS_EN (registers zero/sign flags;
// when undefined both ports are tied to 0).
//
// Ports:
//   clk, rst                 : clock, asynchronous active-high reset
//   op_valid/op_ready        : operation handshake
//   op_a, op_b               : 8-bit operands
//   op_s, op_m, op_cin       : select, mode (1 = logic), low-nibble carry-in
//   alu_a, alu_b, alu_s,
//   alu_m, alu_cin           : drive to the slice (all 0 in IDLE/DONE)
//   alu_f, alu_cout, alu_aeqb: sampled from the slice at the LO/HI edges
//   res_valid/res_ready      : result handshake
//   result, c_out, a_eq_b    : assembled result, high-nibble carry, equality
//   zero, sign               : result flags (feature-dependent)
module alu8_nibble_sequencer #(
    parameter int WORD_W = 8,
    parameter int NIB_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              op_valid,
    output logic              op_ready,
    input  logic [WORD_W-1:0] op_a,
    input  logic [WORD_W-1:0] op_b,
    input  logic [3:0]        op_s,
    input  logic              op_m,
    input  logic              op_cin,
    output logic [NIB_W-1:0]  alu_a,
    output logic [NIB_W-1:0]  alu_b,
    output logic [3:0]        alu_s,
    output logic              alu_m,
    output logic              alu_cin,
    input  logic [NIB_W-1:0]  alu_f,
    input  logic              alu_cout,
    input  logic              alu_aeqb,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [WORD_W-1:0] result,
    output logic              c_out,
    output logic              a_eq_b,
    output logic              zero,
    output logic              sign
);

    import alu8_seq_pkg::*;

    alu8_seq_state_t state_reg, state_next;

    logic [WORD_W-1:0] a_reg, b_reg;
    logic [3:0]        s_reg;
    logic              m_reg;
    logic              cin_reg;
    logic              carry_reg;   // low-nibble carry-out, feeds HI carry-in
    logic              eq_reg;      // low-nibble equality sample
    logic [WORD_W-1:0] result_reg;
    logic              c_out_reg;
    logic              a_eq_b_reg;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (op_valid)  state_next = LO;
            LO:                     state_next = HI;
            HI:                     state_next = DONE;
            DONE:    if (res_ready) state_next = IDLE;
            default:                state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs. The slice is only driven while it is being used so
    // that an idle bus is quiet.
    // ------------------------------------------------------------------
    always_comb begin
        op_ready  = 1'b0;
        res_valid = 1'b0;
        alu_a     = '0;
        alu_b     = '0;
        alu_s     = '0;
        alu_m     = 1'b0;
        alu_cin   = 1'b0;
        case (state_reg)
            IDLE: op_ready = 1'b1;
            LO: begin
                alu_a   = a_reg[NIB_W-1:0];
                alu_b   = b_reg[NIB_W-1:0];
                alu_s   = s_reg;
                alu_m   = m_reg;
                alu_cin = cin_reg;
            end
            HI: begin
                alu_a   = a_reg[WORD_W-1:NIB_W];
                alu_b   = b_reg[WORD_W-1:NIB_W];
                alu_s   = s_reg;
                alu_m   = m_reg;
                alu_cin = carry_reg;   // chained as-is, no polarity change
            end
            DONE: res_valid = 1'b1;
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: operand capture on acceptance, nibble sampling at the
    // LO and HI edges. Everything else holds, which keeps DONE stable.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_reg      <= '0;
            b_reg      <= '0;
            s_reg      <= '0;
            m_reg      <= 1'b0;
            cin_reg    <= 1'b0;
            carry_reg  <= 1'b0;
            eq_reg     <= 1'b0;
            result_reg <= '0;
            c_out_reg  <= 1'b0;
            a_eq_b_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (op_valid) begin
                        a_reg   <= op_a;
                        b_reg   <= op_b;
                        s_reg   <= op_s;
                        m_reg   <= op_m;
                        cin_reg <= op_cin;
                    end
                end
                LO: begin
                    result_reg[NIB_W-1:0] <= alu_f;
                    carry_reg             <= alu_cout;
                    eq_reg                <= alu_aeqb;
                end
                HI: begin
                    result_reg[WORD_W-1:NIB_W] <= alu_f;
                    c_out_reg                  <= alu_cout;
                    a_eq_b_reg                 <= eq_reg & alu_aeqb;
                end
                default: ;
            endcase
        end
    end

    assign result = result_reg;
    assign c_out  = c_out_reg;
    assign a_eq_b = a_eq_b_reg;

`ifdef ALU8_SEQ_FLAGS_EN
    // Flags are derived from the word as it will look after the HI edge:
    // the incoming high nibble joined to the already captured low nibble.
    logic zero_reg, sign_reg;
    logic zero_next, sign_next;

    alu8_seq_flags u_flags (
        .word ({alu_f, result_reg[NIB_W-1:0]}),
        .zero (zero_next),
        .sign (sign_next)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            zero_reg <= 1'b0;
            sign_reg <= 1'b0;
        end else if (state_reg == HI) begin
            zero_reg <= zero_next;
            sign_reg <= sign_next;
        end
    end

    assign zero = zero_reg;
    assign sign = sign_reg;
`else
    assign zero = 1'b0;
    assign sign = 1'b0;
`endif

endmodule

// File: tb/tb_alu8_nibble_sequencer.sv
// Self-checking bench for alu8_nibble_sequencer. A behavioural 4-bit slice
// is attached to the alu_* bus; expected results come from an 8-bit
// reference model computed directly on whole words.
module tb_alu8_nibble_sequencer;

`ifdef ALU8_SEQ_FLAGS_EN
    localparam bit FLAGS_EN = 1'b1;
`else
    localparam bit FLAGS_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       op_valid;
    logic       op_ready;
    logic [7:0] op_a, op_b;
    logic [3:0] op_s;
    logic       op_m, op_cin;
    logic [3:0] alu_a, alu_b, alu_s;
    logic       alu_m, alu_cin;
    logic [3:0] alu_f;
    logic       alu_cout, alu_aeqb;
    logic       res_valid, res_ready;
    logic [7:0] result;
    logic       c_out, a_eq_b, zero, sign;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    alu8_nibble_sequencer dut (
        .clk(clk), .rst(rst),
        .op_valid(op_valid), .op_ready(op_ready),
        .op_a(op_a), .op_b(op_b), .op_s(op_s), .op_m(op_m), .op_cin(op_cin),
        .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s), .alu_m(alu_m), .alu_cin(alu_cin),
        .alu_f(alu_f), .alu_cout(alu_cout), .alu_aeqb(alu_aeqb),
        .res_valid(res_valid), .res_ready(res_ready),
        .result(result), .c_out(c_out), .a_eq_b(a_eq_b), .zero(zero), .sign(sign)
    );

    // Logic-mode function table (active-high 74181 logic column), bitwise.
    function automatic logic [7:0] logic_fn(input logic [3:0] s, input logic [7:0] a, input logic [7:0] b);
        case (s)
            4'h0: return ~a;
            4'h1: return ~(a | b);
            4'h2: return ~a & b;
            4'h3: return 8'h00;
            4'h4: return ~(a & b);
            4'h5: return ~b;
            4'h6: return a ^ b;
            4'h7: return a & ~b;
            4'h8: return ~a | b;
            4'h9: return ~(a ^ b);
            4'hA: return b;
            4'hB: return a & b;
            4'hC: return 8'hFF;
            4'hD: return a | ~b;
            4'hE: return a | b;
            default: return a;
        endcase
    endfunction

    // Behavioural slice: arithmetic = A + B + cin; logic passes cin to cout.
    logic [4:0] slice_sum;
    logic [7:0] slice_log;
    always_comb begin
        slice_sum = {1'b0, alu_a} + {1'b0, alu_b} + {4'b0, alu_cin};
        slice_log = logic_fn(alu_s, {4'b0, alu_a}, {4'b0, alu_b});
        if (alu_m) begin
            alu_f    = slice_log[3:0];
            alu_cout = alu_cin;
        end else begin
            alu_f    = slice_sum[3:0];
            alu_cout = slice_sum[4];
        end
        alu_aeqb = (alu_a == alu_b);
    end

    // Word-level reference model.
    logic [7:0] exp_res;
    logic       exp_cout, exp_eq, exp_lo_carry, exp_zero, exp_sign;
    task automatic ref_model(input logic [7:0] a, input logic [7:0] b, input logic [3:0] s,
                             input logic m, input logic cin);
        logic [8:0] full;
        logic [4:0] low;
        full = {1'b0, a} + {1'b0, b} + {8'b0, cin};
        low  = {1'b0, a[3:0]} + {1'b0, b[3:0]} + {4'b0, cin};
        if (m) begin
            exp_res      = logic_fn(s, a, b);
            exp_cout     = cin;
            exp_lo_carry = cin;
        end else begin
            exp_res      = full[7:0];
            exp_cout     = full[8];
            exp_lo_carry = low[4];
        end
        exp_eq   = (a == b);
        exp_zero = FLAGS_EN && (exp_res == 8'h00);
        exp_sign = FLAGS_EN && exp_res[7];
    endtask

    // Observations captured along one transaction.
    logic [3:0] obs_lo_a, obs_hi_a;
    logic       obs_lo_cin, obs_hi_cin, obs_hi_cout;
    logic       obs_lo_rv, obs_hi_rv, obs_lo_ready, obs_done_rv;
    logic       obs_after_ready, obs_after_rv;

    // Issue one operation and sample the DUT through LO, HI and DONE. With
    // res_ready high it also samples the cycle after DONE.
    task automatic drive_op(input logic [7:0] a, input logic [7:0] b, input logic [3:0] s,
                            input logic m, input logic cin);
        @(negedge clk);
        op_valid = 1'b1; op_a = a; op_b = b; op_s = s; op_m = m; op_cin = cin;
        @(posedge clk); #1;                      // edge N: accepted, now LO
        op_valid = 1'b0;
        obs_lo_a = alu_a; obs_lo_cin = alu_cin; obs_lo_rv = res_valid; obs_lo_ready = op_ready;
        @(posedge clk); #1;                      // edge N+1: HI
        obs_hi_a = alu_a; obs_hi_cin = alu_cin; obs_hi_cout = alu_cout; obs_hi_rv = res_valid;
        @(posedge clk); #1;                      // edge N+2: DONE
        obs_done_rv = res_valid;
        $display("[TB] op a=%h b=%h s=%h m=%0d cin=%0d -> result=%h c_out=%0d a_eq_b=%0d zero=%0d sign=%0d",
                 a, b, s, m, cin, result, c_out, a_eq_b, zero, sign);
        if (res_ready) begin
            @(posedge clk); #1;
            obs_after_ready = op_ready; obs_after_rv = res_valid;
        end
    endtask

    task automatic test_reset();
        tests_run++; if (op_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_op_ready: got %b expected 1", op_ready); end
        tests_run++; if (res_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_res_valid: got %b expected 0", res_valid); end
        tests_run++; if (result !== 8'h00) begin tests_failed++; $display("FAIL reset_result: got %h expected 00", result); end
        tests_run++; if ({c_out, a_eq_b, zero, sign} !== 4'b0) begin tests_failed++; $display("FAIL reset_flags: got %b expected 0000", {c_out, a_eq_b, zero, sign}); end
        tests_run++; if ({alu_a, alu_b, alu_s, alu_m, alu_cin} !== 14'b0) begin tests_failed++; $display("FAIL reset_alu_bus: got %h expected 0", {alu_a, alu_b, alu_s, alu_m, alu_cin}); end
    endtask

    task automatic test_logic_xor();
        ref_model(8'hA5, 8'h0F, 4'b0110, 1'b1, 1'b0);
        drive_op(8'hA5, 8'h0F, 4'b0110, 1'b1, 1'b0);
        tests_run++; if (result !== 8'hAA) begin tests_failed++; $display("FAIL xor_result: got %h expected aa", result); end
        tests_run++; if ({obs_lo_rv, obs_hi_rv, obs_done_rv} !== 3'b001) begin tests_failed++; $display("FAIL xor_latency: got %b expected 001", {obs_lo_rv, obs_hi_rv, obs_done_rv}); end
        tests_run++; if (obs_lo_ready !== 1'b0) begin tests_failed++; $display("FAIL xor_busy_ready: got %b expected 0", obs_lo_ready); end
        tests_run++; if (a_eq_b !== 1'b0) begin tests_failed++; $display("FAIL xor_a_eq_b: got %b expected 0", a_eq_b); end
        tests_run++; if ({obs_lo_a, obs_hi_a} !== 8'h5A) begin tests_failed++; $display("FAIL xor_nibble_order: got %h expected 5a", {obs_lo_a, obs_hi_a}); end
        tests_run++; if ({obs_after_ready, obs_after_rv} !== 2'b10) begin tests_failed++; $display("FAIL xor_release: got %b expected 10", {obs_after_ready, obs_after_rv}); end
    endtask

    task automatic test_carry_chain();
        // 0F + 01: low nibble overflows, high nibble does not.
        drive_op(8'h0F, 8'h01, 4'b1001, 1'b0, 1'b0);
        tests_run++; if (obs_lo_cin !== 1'b0) begin tests_failed++; $display("FAIL carry_lo_cin0: got %b expected 0", obs_lo_cin); end
        tests_run++; if (obs_hi_cin !== 1'b1) begin tests_failed++; $display("FAIL carry_hi_cin: got %b expected 1", obs_hi_cin); end
        tests_run++; if ({result, c_out} !== {8'h10, 1'b0}) begin tests_failed++; $display("FAIL carry_sum1: got %h/%b expected 10/0", result, c_out); end
        // FF + 01 + 1: both nibbles carry.
        drive_op(8'hFF, 8'h01, 4'b1001, 1'b0, 1'b1);
        tests_run++; if (obs_lo_cin !== 1'b1) begin tests_failed++; $display("FAIL carry_lo_cin1: got %b expected 1", obs_lo_cin); end
        tests_run++; if (c_out !== obs_hi_cout) begin tests_failed++; $display("FAIL carry_cout_vs_slice: got %b expected %b", c_out, obs_hi_cout); end
        tests_run++; if ({result, c_out} !== {8'h01, 1'b1}) begin tests_failed++; $display("FAIL carry_sum2: got %h/%b expected 01/1", result, c_out); end
    endtask

    task automatic test_equality();
        drive_op(8'h3C, 8'h3C, 4'b0110, 1'b1, 1'b0);
        tests_run++; if (a_eq_b !== 1'b1) begin tests_failed++; $display("FAIL eq_same: got %b expected 1", a_eq_b); end
        drive_op(8'h3C, 8'h3D, 4'b0110, 1'b1, 1'b0);
        tests_run++; if (a_eq_b !== 1'b0) begin tests_failed++; $display("FAIL eq_low_diff: got %b expected 0", a_eq_b); end
        drive_op(8'h4C, 8'h3C, 4'b0110, 1'b1, 1'b0);
        tests_run++; if (a_eq_b !== 1'b0) begin tests_failed++; $display("FAIL eq_high_diff: got %b expected 0", a_eq_b); end
    endtask

    task automatic test_backpressure();
        res_ready = 1'b0;
        ref_model(8'h12, 8'h34, 4'b1001, 1'b0, 1'b0);
        drive_op(8'h12, 8'h34, 4'b1001, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            op_valid = 1'b1; op_a = 8'($urandom); op_b = 8'($urandom); op_s = 4'h6; op_m = 1'b1;
            @(posedge clk); #1;
            tests_run++; if ({res_valid, op_ready, result, c_out} !== {2'b10, exp_res, exp_cout}) begin
                tests_failed++; $display("FAIL bp_hold_%0d: got rv=%b rdy=%b res=%h c=%b expected rv=1 rdy=0 res=%h c=%b",
                                         i, res_valid, op_ready, result, c_out, exp_res, exp_cout); end
        end
        @(negedge clk);
        op_valid = 1'b0; res_ready = 1'b1;
        @(posedge clk); #1;
        tests_run++; if ({op_ready, res_valid} !== 2'b10) begin tests_failed++; $display("FAIL bp_release: got %b expected 10", {op_ready, res_valid}); end
    endtask

    task automatic test_reset_mid_op();
        @(negedge clk);
        op_valid = 1'b1; op_a = 8'h77; op_b = 8'h11; op_s = 4'b1001; op_m = 1'b0; op_cin = 1'b0;
        @(posedge clk); #1;
        op_valid = 1'b0;
        @(posedge clk); #1;                      // now in HI, low nibble captured
        rst = 1'b1;
        #1;
        tests_run++; if ({res_valid, result, op_ready} !== {1'b0, 8'h00, 1'b1}) begin
            tests_failed++; $display("FAIL rst_mid: got rv=%b res=%h rdy=%b expected rv=0 res=00 rdy=1", res_valid, result, op_ready); end
        tests_run++; if ({alu_a, alu_cin} !== 5'b0) begin tests_failed++; $display("FAIL rst_mid_bus: got %h expected 0", {alu_a, alu_cin}); end
        @(negedge clk);
        rst = 1'b0;
        ref_model(8'h77, 8'h11, 4'b1001, 1'b0, 1'b1);
        drive_op(8'h77, 8'h11, 4'b1001, 1'b0, 1'b1);
        tests_run++; if ({result, c_out, obs_done_rv} !== {exp_res, exp_cout, 1'b1}) begin
            tests_failed++; $display("FAIL rst_next_op: got %h/%b/%b expected %h/%b/1", result, c_out, obs_done_rv, exp_res, exp_cout); end
    endtask

    task automatic test_flags();
        drive_op(8'h5A, 8'hC3, 4'b0011, 1'b1, 1'b0);
        tests_run++; if ({result, zero, sign} !== {8'h00, FLAGS_EN, 1'b0}) begin
            tests_failed++; $display("FAIL flags_zero: got %h z=%b s=%b expected 00 z=%b s=0", result, zero, sign, FLAGS_EN); end
        drive_op(8'h80, 8'h5A, 4'b1111, 1'b1, 1'b0);
        tests_run++; if ({result, zero, sign} !== {8'h80, 1'b0, FLAGS_EN}) begin
            tests_failed++; $display("FAIL flags_sign: got %h z=%b s=%b expected 80 z=0 s=%b", result, zero, sign, FLAGS_EN); end
    endtask

    task automatic test_random();
        logic [7:0] a, b;
        logic [3:0] s;
        logic       m, cin;
        for (int i = 0; i < 24; i++) begin
            a = 8'($urandom); b = 8'($urandom); s = 4'($urandom);
            m = 1'($urandom); cin = 1'($urandom);
            if ($urandom_range(0, 3) == 0) b = a;
            ref_model(a, b, s, m, cin);
            drive_op(a, b, s, m, cin);
            tests_run++; if ({result, c_out, a_eq_b, zero, sign} !== {exp_res, exp_cout, exp_eq, exp_zero, exp_sign}) begin
                tests_failed++; $display("FAIL rand_%0d_out: got %h c=%b eq=%b z=%b s=%b expected %h c=%b eq=%b z=%b s=%b",
                                         i, result, c_out, a_eq_b, zero, sign, exp_res, exp_cout, exp_eq, exp_zero, exp_sign); end
            tests_run++; if ({obs_lo_cin, obs_hi_cin, obs_done_rv, obs_after_ready} !== {cin, exp_lo_carry, 2'b11}) begin
                tests_failed++; $display("FAIL rand_%0d_seq: got %b expected %b", i,
                                         {obs_lo_cin, obs_hi_cin, obs_done_rv, obs_after_ready}, {cin, exp_lo_carry, 2'b11}); end
        end
    endtask

    initial begin
        rst = 1'b1; op_valid = 1'b0; res_ready = 1'b1;
        op_a = '0; op_b = '0; op_s = '0; op_m = 1'b0; op_cin = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        @(negedge clk);
        rst = 1'b0;
        #1;
        test_reset();
        test_logic_xor();
        test_carry_chain();
        test_equality();
        test_backpressure();
        test_reset_mid_op();
        test_flags();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
